multi_sonar_scanner: RTL and testbench
======================================

MULTI_SONAR_SCANNER -- requirements
Module: multi_sonar_scanner

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of HC-SR04 channels (1..8).
REQ-002 SHALL have parameter DIST_W, default 8, distance width in cm.
REQ-003 SHALL have parameter TRIG_CYC, default 10, trigger pulse length in CLK cycles.
REQ-004 SHALL have parameter CYC_PER_CM, default 58, echo CLK cycles per cm.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 38000, maximum cycles for echo wait and for echo width.
REQ-006 SHALL have parameter GUARD_CYC, default 2000, idle cycles between channels.
REQ-007 SHALL have port CLK  input  1  trigger-domain clock.
REQ-008 SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-009 SHALL have port Enable  input  1  scanning allowed.
REQ-010 SHALL have port Echo  input  N_CH  raw echo lines, asynchronous.
REQ-011 SHALL have port Threshold  input  DIST_W  intrusion distance in cm.
REQ-012 SHALL have port Trigger  output  N_CH  trigger lines, one-hot or zero.
REQ-013 SHALL have port Distance  output  N_CH*DIST_W  last distance per channel; channel k at bits [k*DIST_W +: DIST_W].
REQ-014 SHALL have port Valid  output  1  one-cycle pulse when a channel result updates.
REQ-015 SHALL have port Ch_Idx  output  max(1,clog2(N_CH))  channel of the current or last measurement.
REQ-016 SHALL have port Timeout  output  N_CH  per-channel flag; last measurement timed out.
REQ-017 SHALL have port Intrude  output  N_CH  per-channel intrusion flag.
REQ-018 SHALL have port Alarm  output  1  OR of Intrude.

Function
REQ-019 SHALL pass each Echo bit through a 2-flop synchroniser; all echo timing SHALL use the synchronised value, adding 2 cycles of latency.
REQ-020 SHALL implement FSM IDLE->TRIG->WAIT_ECHO->MEASURE->GUARD->IDLE.
REQ-021 IDLE: when Enable=1, SHALL go to TRIG on the next cycle; when Enable=0, SHALL stay in IDLE.
REQ-022 TRIG: SHALL drive Trigger[Ch_Idx]=1 for exactly TRIG_CYC cycles, then go to WAIT_ECHO.
REQ-023 WAIT_ECHO: SHALL go to MEASURE on the synchronised echo rising edge; after TIMEOUT_CYC cycles with no rising edge, SHALL set the timeout result and go to GUARD.
REQ-024 MEASURE: SHALL count CLK cycles in a sub-counter; SHALL increment cm and clear the sub-counter each time the sub-counter reaches CYC_PER_CM-1; cm SHALL saturate at 2^DIST_W-1.
REQ-025 MEASURE: on the echo falling edge SHALL write cm to Distance[Ch_Idx], clear Timeout[Ch_Idx], pulse Valid, and go to GUARD.
REQ-026 MEASURE: when echo is high for TIMEOUT_CYC cycles SHALL set the timeout result and go to GUARD.
REQ-027 Timeout result SHALL be: Distance[Ch_Idx]=all ones, Timeout[Ch_Idx]=1, Valid pulse.
REQ-028 GUARD: SHALL wait GUARD_CYC cycles, then advance Ch_Idx, wrapping N_CH-1->0, and go to IDLE.
REQ-029 Enable deassertion mid-cycle SHALL NOT abort the measurement; the FSM SHALL halt in IDLE.
REQ-030 Intrude[k] SHALL be evaluated on each Valid for channel k: below = (Distance<Threshold) and not timeout.
REQ-031 Valid, Distance, Timeout and Intrude SHALL update in the same cycle; Alarm SHALL follow combinationally from Intrude.

Reset
REQ-032 While RST=1 SHALL force: state IDLE; Trigger=0; Valid=0; Ch_Idx=0; Distance all ones; Timeout=0; Intrude=0; counters=0; synchronisers=0.
REQ-033 Reset mid-measurement SHALL discard the measurement with no Valid pulse.

Configuration
REQ-034 With SONAR_HYST_EN defined, Intrude[k] SHALL set after 2 consecutive below readings on channel k and clear after 2 consecutive not-below readings, using a per-channel 2-bit history.
REQ-035 Without SONAR_HYST_EN, Intrude[k] SHALL equal the below condition of the latest reading.

Structure
REQ-036 Package sonar_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-037 Sub-module echo_timer SHALL implement the cycle/cm counters, saturation and timeout detection, with one instance shared across channels.

Verification
REQ-038 N_CH=4, Echo[0] high for 580 cycles -> Distance[0]=10, Valid pulse with Ch_Idx=0, Timeout[0]=0.
REQ-039 No echo on channel 1 -> after 38000 cycles Distance[1]=255, Timeout[1]=1, Valid pulse.
REQ-040 Echo high for 20000 cycles -> Distance=255 (saturated), Timeout=0.
REQ-041 Threshold=50, channel 2 reading 30: without the macro -> Intrude[2]=1 and Alarm=1 on the first Valid; with SONAR_HYST_EN -> set only on the second reading, clear only after two readings of 80.
REQ-042 RST pulsed during MEASURE on channel 3 -> all outputs at reset values, no Valid, next scan starts at channel 0.
REQ-043 Trigger SHALL be checked one-hot, TRIG_CYC wide, with channel order 0,1,2,3,0 and GUARD_CYC spacing.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared FSM state encoding and default parameter values for the multi-channel
// HC-SR04 sonar scanner.
package sonar_pkg;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_DIST_W      = 8;
  localparam int DEF_TRIG_CYC    = 10;
  localparam int DEF_CYC_PER_CM  = 58;
  localparam int DEF_TIMEOUT_CYC = 38000;
  localparam int DEF_GUARD_CYC   = 2000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_ECHO = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_GUARD     = 3'd4
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/echo_timer.sv
// Shared phase counter plus cycle-to-centimetre converter with saturation.
// One instance serves every channel because only one channel is measured at a time.
module echo_timer
  import sonar_pkg::*;
#(
  parameter int DIST_W     = DEF_DIST_W,
  parameter int CYC_PER_CM = DEF_CYC_PER_CM,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              start,
  input  logic              tick,
  input  logic              meas,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [DIST_W-1:0] cm
);

  localparam int SUB_W = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;

  logic [SUB_W-1:0]  sub_cnt;
  logic [SUB_W-1:0]  base_sub;
  logic [SUB_W-1:0]  sub_step;
  logic [DIST_W-1:0] base_cm;
  logic [DIST_W-1:0] cm_step;

  // start counts the first high cycle of the echo from a zeroed base, so the
  // detecting cycle itself contributes to the distance
  always_comb begin
    base_sub = start ? '0 : sub_cnt;
    base_cm  = start ? '0 : cm;
    sub_step = base_sub + 1'b1;
    cm_step  = base_cm;
    if (base_sub == SUB_W'(CYC_PER_CM - 1)) begin
      sub_step = '0;
      cm_step  = (base_cm == '1) ? base_cm : base_cm + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      sub_cnt   <= '0;
      cm        <= '0;
    end else if (clear) begin
      cycle_cnt <= '0;
      sub_cnt   <= '0;
      cm        <= '0;
    end else if (start) begin
      cycle_cnt <= CNT_W'(1);
      sub_cnt   <= sub_step;
      cm        <= cm_step;
    end else begin
      if (tick) cycle_cnt <= cycle_cnt + 1'b1;
      if (meas) begin
        sub_cnt <= sub_step;
        cm      <= cm_step;
      end
    end
  end

endmodule

// File: rtl/multi_sonar_scanner.sv
// Round-robin HC-SR04 scanner: triggers each channel in turn, times its echo and
// flags intrusions below Threshold. Define SONAR_HYST_EN for two-reading hysteresis.
module multi_sonar_scanner
  import sonar_pkg::*;
#(
  parameter int  N_CH        = DEF_N_CH,
  parameter int  DIST_W      = DEF_DIST_W,
  parameter int  TRIG_CYC    = DEF_TRIG_CYC,
  parameter int  CYC_PER_CM  = DEF_CYC_PER_CM,
  parameter int  TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int  GUARD_CYC   = DEF_GUARD_CYC,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Enable,
  input  logic [N_CH-1:0]          Echo,
  input  logic [DIST_W-1:0]        Threshold,
  output logic [N_CH-1:0]          Trigger,
  output logic [N_CH*DIST_W-1:0]   Distance,
  output logic                     Valid,
  output logic [CH_W-1:0]          Ch_Idx,
  output logic [N_CH-1:0]          Timeout,
  output logic [N_CH-1:0]          Intrude,
  output logic                     Alarm
);

  localparam int CNT_W = $clog2(max3(TIMEOUT_CYC, GUARD_CYC, TRIG_CYC) + 1);

  state_e              state;
  logic [CH_W-1:0]     ch_idx;
  logic                valid_r;
  logic [N_CH*DIST_W-1:0] dist_r;
  logic [N_CH-1:0]     to_r;
  logic [N_CH-1:0]     intr_r;
  logic [N_CH-1:0]     echo_s1, echo_s2, echo_d;

  logic                echo_cur, echo_rise;
  logic [CNT_W-1:0]    cycle_cnt;
  logic [DIST_W-1:0]   cm;
  logic                trig_done, guard_done, cnt_limit;
  logic                t_clear, t_start, t_tick, t_meas;
  logic                res_we, res_to, res_below;
  logic [DIST_W-1:0]   res_dist;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      echo_s1 <= '0;
      echo_s2 <= '0;
      echo_d  <= '0;
    end else begin
      echo_s1 <= Echo;
      echo_s2 <= echo_s1;
      echo_d  <= echo_s2;
    end
  end

  assign echo_cur   = echo_s2[ch_idx];
  assign echo_rise  = echo_s2[ch_idx] & ~echo_d[ch_idx];
  assign trig_done  = (cycle_cnt == CNT_W'(TRIG_CYC - 1));
  assign guard_done = (cycle_cnt == CNT_W'(GUARD_CYC - 1));
  assign cnt_limit  = (cycle_cnt >= CNT_W'(TIMEOUT_CYC - 1));

  echo_timer #(
    .DIST_W     (DIST_W),
    .CYC_PER_CM (CYC_PER_CM),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk       (CLK),
    .rst       (RST),
    .clear     (t_clear),
    .start     (t_start),
    .tick      (t_tick),
    .meas      (t_meas),
    .cycle_cnt (cycle_cnt),
    .cm        (cm)
  );

  // The timer is zeroed on every phase change so each phase counts from zero;
  // in MEASURE the cycle count doubles as the echo-width watchdog
  always_comb begin
    t_clear  = 1'b0;
    t_start  = 1'b0;
    t_tick   = 1'b0;
    t_meas   = 1'b0;
    res_we   = 1'b0;
    res_to   = 1'b0;
    res_dist = '1;
    case (state)
      ST_IDLE: t_clear = 1'b1;
      ST_TRIG: begin
        if (trig_done) t_clear = 1'b1;
        else           t_tick  = 1'b1;
      end
      ST_WAIT_ECHO: begin
        if (echo_rise) t_start = 1'b1;
        else if (cnt_limit) begin
          t_clear = 1'b1;
          res_we  = 1'b1;
          res_to  = 1'b1;
        end else t_tick = 1'b1;
      end
      ST_MEASURE: begin
        if (!echo_cur) begin
          t_clear  = 1'b1;
          res_we   = 1'b1;
          res_dist = cm;
        end else if (cnt_limit) begin
          t_clear = 1'b1;
          res_we  = 1'b1;
          res_to  = 1'b1;
        end else begin
          t_tick = 1'b1;
          t_meas = 1'b1;
        end
      end
      ST_GUARD: begin
        if (guard_done) t_clear = 1'b1;
        else            t_tick  = 1'b1;
      end
      default: t_clear = 1'b1;
    endcase
  end

  assign res_below = !res_to && (res_dist < Threshold);

`ifdef SONAR_HYST_EN
  logic [1:0] hist_r [N_CH];
  logic [1:0] hist_next;
  assign hist_next = {hist_r[ch_idx][0], res_below};
`endif

  // Enable is only sampled in IDLE, so dropping it lets the current channel finish
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      ch_idx  <= '0;
      valid_r <= 1'b0;
      dist_r  <= '1;
      to_r    <= '0;
      intr_r  <= '0;
`ifdef SONAR_HYST_EN
      for (int k = 0; k < N_CH; k++) hist_r[k] <= 2'b00;
`endif
    end else begin
      valid_r <= 1'b0;
      case (state)
        ST_IDLE:      if (Enable) state <= ST_TRIG;
        ST_TRIG:      if (trig_done) state <= ST_WAIT_ECHO;
        ST_WAIT_ECHO: begin
          if (echo_rise)   state <= ST_MEASURE;
          else if (res_we) state <= ST_GUARD;
        end
        ST_MEASURE:   if (res_we) state <= ST_GUARD;
        ST_GUARD: begin
          if (guard_done) begin
            ch_idx <= (ch_idx == CH_W'(N_CH - 1)) ? '0 : ch_idx + 1'b1;
            state  <= ST_IDLE;
          end
        end
        default:      state <= ST_IDLE;
      endcase

      if (res_we) begin
        valid_r                          <= 1'b1;
        dist_r[ch_idx*DIST_W +: DIST_W]  <= res_dist;
        to_r[ch_idx]                     <= res_to;
`ifdef SONAR_HYST_EN
        hist_r[ch_idx] <= hist_next;
        if (hist_next == 2'b11)      intr_r[ch_idx] <= 1'b1;
        else if (hist_next == 2'b00) intr_r[ch_idx] <= 1'b0;
`else
        intr_r[ch_idx] <= res_below;
`endif
      end
    end
  end

  always_comb begin
    Trigger = '0;
    if (state == ST_TRIG) Trigger[ch_idx] = 1'b1;
  end

  assign Distance = dist_r;
  assign Valid    = valid_r;
  assign Ch_Idx   = ch_idx;
  assign Timeout  = to_r;
  assign Intrude  = intr_r;
  assign Alarm    = |intr_r;

endmodule

// File: tb/tb_multi_sonar_scanner.sv
// Randomised bench for multi_sonar_scanner against a reading-level reference model.
// Timing parameters are scaled down so full scans, timeouts and saturation fit a short run.
module tb_multi_sonar_scanner;

  localparam int N_CH        = 4;
  localparam int DIST_W      = 8;
  localparam int TRIG_CYC    = 10;
  localparam int CYC_PER_CM  = 10;
  localparam int TIMEOUT_CYC = 4000;
  localparam int GUARD_CYC   = 200;
  localparam int THRESH      = 50;
  localparam int MAX_D       = (1 << DIST_W) - 1;

  logic                   CLK = 1'b0;
  logic                   RST;
  logic                   Enable;
  logic [N_CH-1:0]        Echo;
  logic [DIST_W-1:0]      Threshold;
  logic [N_CH-1:0]        Trigger;
  logic [N_CH*DIST_W-1:0] Distance;
  logic                   Valid;
  logic [1:0]             Ch_Idx;
  logic [N_CH-1:0]        Timeout;
  logic [N_CH-1:0]        Intrude;
  logic                   Alarm;

  int n_checks = 0;
  int n_fail   = 0;

  int m_dist [N_CH];
  bit m_to   [N_CH];
  bit m_intr [N_CH];
  bit m_prev [N_CH];

  int plan_h  [16];
  bit plan_on [16];

  multi_sonar_scanner #(
    .N_CH        (N_CH),
    .DIST_W      (DIST_W),
    .TRIG_CYC    (TRIG_CYC),
    .CYC_PER_CM  (CYC_PER_CM),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .GUARD_CYC   (GUARD_CYC)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Enable    (Enable),
    .Echo      (Echo),
    .Threshold (Threshold),
    .Trigger   (Trigger),
    .Distance  (Distance),
    .Valid     (Valid),
    .Ch_Idx    (Ch_Idx),
    .Timeout   (Timeout),
    .Intrude   (Intrude),
    .Alarm     (Alarm)
  );

  always #5 CLK = ~CLK;

  initial begin
    #(90000 * 10);
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N_CH; i++) begin
      m_dist[i] = MAX_D;
      m_to[i]   = 1'b0;
      m_intr[i] = 1'b0;
      m_prev[i] = 1'b0;
    end
  endtask

  // One reading: distance is whole centimetres of echo-high time, saturating;
  // a missing or over-long echo reports all ones with the timeout flag
  task automatic modelReading(input int ch, input bit echo_on, input int high_cyc);
    int d;
    bit to, below;
    if (!echo_on || high_cyc >= TIMEOUT_CYC) begin
      d  = MAX_D;
      to = 1'b1;
    end else begin
      d  = high_cyc / CYC_PER_CM;
      if (d > MAX_D) d = MAX_D;
      to = 1'b0;
    end
    below = !to && (d < THRESH);
`ifdef SONAR_HYST_EN
    if (below && m_prev[ch])        m_intr[ch] = 1'b1;
    else if (!below && !m_prev[ch]) m_intr[ch] = 1'b0;
    m_prev[ch] = below;
`else
    m_intr[ch] = below;
`endif
    m_dist[ch] = d;
    m_to[ch]   = to;
  endtask

  task automatic checkModel(input string tag);
    logic [N_CH*DIST_W-1:0] ed;
    logic [N_CH-1:0]        et, ei;
    for (int i = 0; i < N_CH; i++) begin
      ed[i*DIST_W +: DIST_W] = DIST_W'(m_dist[i]);
      et[i] = m_to[i];
      ei[i] = m_intr[i];
    end
    checkOutput({tag, "_distance"}, Distance, ed);
    checkOutput({tag, "_timeout"},  Timeout,  et);
    checkOutput({tag, "_intrude"},  Intrude,  ei);
    checkOutput({tag, "_alarm"},    Alarm,    |ei);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_trigger"}, Trigger, 0);
    checkOutput({tag, "_valid"},   Valid,   0);
    checkOutput({tag, "_ch_idx"},  Ch_Idx,  0);
    checkModel(tag);
  endtask

  // Waits for the channel's trigger, checks it, answers with an echo and checks the result
  task automatic applyStimulus(input int exp_ch, input bit echo_on, input int high_cyc,
                               input bit check_gap, input bit drop_enable);
    int cnt, extra, w, t, delay;
    bit got, seen;
    cnt = 0; extra = 0; got = 1'b0;
    while (!got && cnt < TIMEOUT_CYC) begin
      @(negedge CLK);
      cnt++;
      if (Trigger != 0) got = 1'b1;
      else if (Valid)   extra++;
    end
    checkOutput("trig_seen", got, 1);
    if (check_gap) begin
      checkOutput("guard_gap", cnt, GUARD_CYC + 1);
      checkOutput("valid_width", extra, 0);
    end
    checkOutput("trig_onehot", Trigger, 1 << exp_ch);
    checkOutput("ch_idx_trig", Ch_Idx, exp_ch);
    w = 1;
    while (w < TRIG_CYC + 5) begin
      @(negedge CLK);
      if (Trigger != 0) w++;
      else break;
    end
    checkOutput("trig_width", w, TRIG_CYC);

    delay = $urandom_range(1, 20);
    t = 0; seen = 1'b0;
    while (!seen && t < delay + 2 * TIMEOUT_CYC + 50) begin
      if (echo_on && t == delay) begin
        Echo[exp_ch] = 1'b1;
        if (drop_enable) Enable = 1'b0;
      end
      if (echo_on && t == delay + high_cyc) Echo[exp_ch] = 1'b0;
      @(negedge CLK);
      t++;
      if (Valid) seen = 1'b1;
    end
    Echo = '0;
    checkOutput("valid_seen", seen, 1);
    modelReading(exp_ch, echo_on, high_cyc);
    checkOutput("ch_idx_valid", Ch_Idx, exp_ch);
    checkModel("result");
  endtask

  initial begin
    int cnt, vcnt;
    RST = 1'b1; Enable = 1'b0; Echo = '0; Threshold = DIST_W'(THRESH);
    repeat (3) @(negedge CLK);
    modelReset();
    checkReset("reset");
    RST = 1'b0;
    Enable = 1'b1;

    for (int i = 0; i < 16; i++) begin
      plan_on[i] = 1'b1;
      plan_h[i]  = $urandom_range(5, 1200);
    end
    plan_h[0]  = 100;
    plan_on[1] = 1'b0;
    plan_h[2]  = 300;
    plan_h[3]  = 3000;
    plan_h[6]  = 300 + $urandom_range(0, 9);
    plan_h[10] = 800;
    plan_h[11] = 4200;
    plan_h[14] = 800 + $urandom_range(0, 9);
    for (int i = 0; i < 16; i++)
      applyStimulus(i % N_CH, plan_on[i], plan_h[i], i != 0, 1'b0);

    // Dropping Enable mid-measurement completes the reading, then the scan halts
    applyStimulus(0, 1'b1, $urandom_range(5, 600), 1'b1, 1'b1);
    cnt = 0;
    repeat (GUARD_CYC + 100) begin
      @(negedge CLK);
      if (Trigger != 0) cnt++;
    end
    checkOutput("halt_no_trig", cnt, 0);
    checkOutput("halt_ch_idx", Ch_Idx, 1);
    Enable = 1'b1;
    applyStimulus(1, 1'b1, $urandom_range(5, 600), 1'b0, 1'b0);
    applyStimulus(2, 1'b1, $urandom_range(5, 600), 1'b1, 1'b0);

    // Reset while channel 3 is measuring must discard the reading
    cnt = 0;
    while (Trigger == 0 && cnt < TIMEOUT_CYC) begin
      @(negedge CLK);
      cnt++;
    end
    checkOutput("rst_trig_ch3", Trigger, 4'b1000);
    cnt = 0;
    while (Trigger != 0 && cnt < 2 * TRIG_CYC) begin
      @(negedge CLK);
      cnt++;
    end
    repeat (5) @(negedge CLK);
    Echo[3] = 1'b1;
    vcnt = 0;
    repeat (60) begin
      @(negedge CLK);
      if (Valid) vcnt++;
    end
    RST = 1'b1;
    @(negedge CLK);
    modelReset();
    checkReset("midrst");
    Echo = '0;
    repeat (3) begin
      @(negedge CLK);
      if (Valid) vcnt++;
    end
    RST = 1'b0;
    checkOutput("midrst_no_valid", vcnt, 0);
    applyStimulus(0, 1'b1, $urandom_range(5, 600), 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
